// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared opcodes, ALU functs, FSM states and flag indices for the SISC control core
package sisc_pkg;

  // Opcodes (ir[31:28])
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ALU  = 4'h1;
  localparam logic [3:0] OP_ALUI = 4'h2;
  localparam logic [3:0] OP_BRA  = 4'h4;
  localparam logic [3:0] OP_BRR  = 4'h5;
  localparam logic [3:0] OP_BNE  = 4'h6;
  localparam logic [3:0] OP_BNR  = 4'h7;
  localparam logic [3:0] OP_LOD  = 4'h8;
  localparam logic [3:0] OP_STR  = 4'h9;
  localparam logic [3:0] OP_SWP  = 4'hA;
  localparam logic [3:0] OP_HLT  = 4'hF;

  // ALU functions (ir[27:24] for ALU opcodes)
  localparam logic [3:0] FN_ADD = 4'h1;
  localparam logic [3:0] FN_SUB = 4'h2;
  localparam logic [3:0] FN_NOT = 4'h3;
  localparam logic [3:0] FN_OR  = 4'h4;
  localparam logic [3:0] FN_AND = 4'h5;
  localparam logic [3:0] FN_XOR = 4'h6;
  localparam logic [3:0] FN_SHL = 4'h8;
  localparam logic [3:0] FN_SHR = 4'h9;

  // Status / condition-code bit positions in {C,V,N,Z}
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  // RF write-address selects
  localparam logic [1:0] RD_RD   = 2'd0;
  localparam logic [1:0] RD_RB   = 2'd1;
  localparam logic [1:0] RD_SWAP = 2'd2;

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_e;

  // Branch condition: positive forms need any masked flag set, negated forms need none.
  // A zero mask therefore makes BRA/BRR never taken and BNE/BNR always taken.
  function automatic logic br_cond(input logic [3:0] op, input logic [3:0] stat,
                                   input logic [3:0] mm);
    logic hit;
    hit = |(stat & mm);
    case (op)
      OP_BRA, OP_BRR: br_cond = hit;
      OP_BNE, OP_BNR: br_cond = ~hit;
      default:        br_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sisc_exec_ctrl_if.sv
// rtl/sisc_exec_ctrl_if.sv - datapath-facing bus of the SISC control core
interface sisc_exec_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 16
) ();
  logic [31:0]   ir;
  logic [3:0]    stat;
  logic [DW-1:0] rsa;
  logic [DW-1:0] rsb;
  logic [AW-1:0] pc_inc;

  logic [DW-1:0] alu_result;
  logic [3:0]    cc;
  logic          cc_en;
  logic [AW-1:0] br_addr;
  logic          pc_sel;
  logic          pc_write;
  logic          pc_rst;
  logic          rf_we;
  logic          wb_sel;
  logic          mm_sel;
  logic          dm_we;
  logic [1:0]    rd_sel;
  logic          swap_mux;
  logic          swap_data_sel;
  logic          swap_reg_sel;
  logic          swap_en;

  // Datapath side: supplies instruction/operands, consumes controls
  modport master (
    output ir, stat, rsa, rsb, pc_inc,
    input  alu_result, cc, cc_en, br_addr, pc_sel, pc_write, pc_rst,
    input  rf_we, wb_sel, mm_sel, dm_we, rd_sel,
    input  swap_mux, swap_data_sel, swap_reg_sel, swap_en
  );

  // Control core side
  modport slave (
    input  ir, stat, rsa, rsb, pc_inc,
    output alu_result, cc, cc_en, br_addr, pc_sel, pc_write, pc_rst,
    output rf_we, wb_sel, mm_sel, dm_we, rd_sel,
    output swap_mux, swap_data_sel, swap_reg_sel, swap_en
  );
endinterface

// File: rtl/sisc_alu.sv
// rtl/sisc_alu.sv - combinational SISC ALU with {C,V,N,Z} flag generation
module sisc_alu
  import sisc_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [3:0]    funct,
  output logic [DW-1:0] result,
  output logic [3:0]    flags
);
  localparam int SW = $clog2(DW);

  logic [DW:0]   add_w;
  logic [DW:0]   sub_w;
  logic [DW:0]   shl_w;
  logic [DW:0]   shr_w;
  logic [SW-1:0] shamt;
  logic          c_flag;
  logic          v_flag;

  // Extra top bit catches carry / not-borrow; extra bit beyond the shift holds the last bit shifted out
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
  assign shamt = b[SW-1:0];
  assign shl_w = {1'b0, a} << shamt;
  assign shr_w = {a, 1'b0} >> shamt;

  // Function select and carry/overflow
  always_comb begin
    result = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (funct)
      FN_ADD: begin
        result = add_w[DW-1:0];
        c_flag = add_w[DW];
        v_flag = (a[DW-1] == b[DW-1]) && (add_w[DW-1] != a[DW-1]);
      end
      FN_SUB: begin
        result = sub_w[DW-1:0];
        c_flag = sub_w[DW];
        v_flag = (a[DW-1] != b[DW-1]) && (sub_w[DW-1] != a[DW-1]);
      end
      FN_NOT: result = ~a;
      FN_OR:  result = a | b;
      FN_AND: result = a & b;
      FN_XOR: result = a ^ b;
      FN_SHL: begin
        result = shl_w[DW-1:0];
        c_flag = shl_w[DW];
      end
      FN_SHR: begin
        result = shr_w[DW:1];
        c_flag = shr_w[0];
      end
      default: result = '0;
    endcase
  end

  assign flags[FLAG_C] = c_flag;
  assign flags[FLAG_V] = v_flag;
  assign flags[FLAG_N] = result[DW-1];
  assign flags[FLAG_Z] = (result == '0);

endmodule

// File: rtl/sisc_exec_ctrl.sv
// rtl/sisc_exec_ctrl.sv - SISC execution/control core: ALU, branch adder, sequencing FSM (option SISC_SWAP_EN)
module sisc_exec_ctrl
  import sisc_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  sisc_exec_ctrl_if.slave  bus
);
  state_e state_q, state_d;

  logic [3:0]    opcode;
  logic [3:0]    mm;
  logic [15:0]   imm;
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_funct;
  logic          is_mem_op;
  logic          taken;
  logic          unused_ir;

  logic          pc_sel, pc_write, pc_rst, cc_en;
  logic          rf_we, wb_sel, mm_sel, dm_we;
  logic [1:0]    rd_sel;
  logic          swap_data_sel, swap_reg_sel, swap_en;
  logic [AW-1:0] br_addr;

  assign opcode    = bus.ir[31:28];
  assign mm        = bus.ir[27:24];
  assign imm       = bus.ir[15:0];
  assign imm_ext   = {{(DW-16){imm[15]}}, imm};
  // Register addresses are consumed by the register file directly
  assign unused_ir = ^bus.ir[23:16];

  // Loads/stores reuse the adder for rsa+imm; ALU-immediate swaps rsb for the extended immediate
  assign is_mem_op = (opcode == OP_LOD) || (opcode == OP_STR);
  assign alu_b     = (opcode == OP_ALUI || is_mem_op) ? imm_ext : bus.rsb;
  assign alu_funct = is_mem_op ? FN_ADD : mm;

  sisc_alu #(.DW(DW)) u_alu (
    .a      (bus.rsa),
    .b      (alu_b),
    .funct  (alu_funct),
    .result (bus.alu_result),
    .flags  (bus.cc)
  );

  assign taken = br_cond(opcode, bus.stat, mm);

  // Branch target: absolute for BRA/BNE, PC-relative (wrapping) for BRR/BNR
  always_comb begin
    br_addr = '0;
    case (opcode)
      OP_BRA, OP_BNE: br_addr = imm_ext[AW-1:0];
      OP_BRR, OP_BNR: br_addr = bus.pc_inc + imm_ext[AW-1:0];
      default:        br_addr = '0;
    endcase
  end

  // Instruction sequencing: START once after reset, then five states per instruction
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:     state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = (opcode == OP_HLT) ? S_HALT : S_EXECUTE;
      S_EXECUTE:   state_d = S_MEM;
      S_MEM:       state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_START;
    endcase
  end

  // State register; reset wins over any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst_f) state_q <= S_START;
    else       state_q <= state_d;
  end

  // Moore control decode from state and instruction
  always_comb begin
    pc_sel        = 1'b0;
    pc_write      = 1'b0;
    pc_rst        = 1'b0;
    cc_en         = 1'b0;
    rf_we         = 1'b0;
    wb_sel        = 1'b0;
    mm_sel        = 1'b0;
    dm_we         = 1'b0;
    rd_sel        = RD_RD;
    swap_data_sel = 1'b0;
    swap_reg_sel  = 1'b0;
    swap_en       = 1'b0;
    case (state_q)
      S_START: pc_rst = 1'b1;
      S_FETCH: pc_write = 1'b1;
      S_DECODE: begin
        if (taken) begin
          pc_write = 1'b1;
          pc_sel   = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (opcode == OP_ALU || opcode == OP_ALUI) cc_en = 1'b1;
`ifdef SISC_SWAP_EN
        if (opcode == OP_SWP) swap_en = 1'b1;
`endif
      end
      S_MEM: begin
        if (is_mem_op) mm_sel = mm[0];
        if (opcode == OP_STR) dm_we = 1'b1;
`ifdef SISC_SWAP_EN
        if (opcode == OP_SWP) begin
          rf_we         = 1'b1;
          rd_sel        = RD_SWAP;
          swap_data_sel = 1'b1;
        end
`endif
      end
      S_WRITEBACK: begin
        if (is_mem_op) mm_sel = mm[0];
        if (opcode == OP_ALU || opcode == OP_ALUI) rf_we = 1'b1;
        if (opcode == OP_LOD) begin
          rf_we  = 1'b1;
          rd_sel = RD_RB;
          wb_sel = 1'b1;
        end
`ifdef SISC_SWAP_EN
        if (opcode == OP_SWP) begin
          rf_we        = 1'b1;
          rd_sel       = RD_SWAP;
          swap_reg_sel = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

`ifdef SISC_SWAP_EN
  // Normal writeback path only selected while an ALU/LOD result is being written
  assign bus.swap_mux = (state_q == S_WRITEBACK) &&
                        (opcode == OP_ALU || opcode == OP_ALUI || opcode == OP_LOD);
`else
  assign bus.swap_mux = 1'b1;
`endif

  assign bus.pc_sel        = pc_sel;
  assign bus.pc_write      = pc_write;
  assign bus.pc_rst        = pc_rst;
  assign bus.cc_en         = cc_en;
  assign bus.rf_we         = rf_we;
  assign bus.wb_sel        = wb_sel;
  assign bus.mm_sel        = mm_sel;
  assign bus.dm_we         = dm_we;
  assign bus.rd_sel        = rd_sel;
  assign bus.swap_data_sel = swap_data_sel;
  assign bus.swap_reg_sel  = swap_reg_sel;
  assign bus.swap_en       = swap_en;
  assign bus.br_addr       = br_addr;

endmodule

// File: tb/tb_sisc_exec_ctrl.sv
// tb/tb_sisc_exec_ctrl.sv - directed self-checking bench for sisc_exec_ctrl
module tb_sisc_exec_ctrl;

  logic clk = 1'b0;
  logic rst_f;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sisc_exec_ctrl_if #(.DW(32), .AW(16)) bus ();

  sisc_exec_ctrl #(.DW(32), .AW(16)) dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus.slave)
  );

  // Control vector bit masks
  localparam logic [12:0] C_NONE  = 13'h0000;
  localparam logic [12:0] C_CCEN  = 13'h1000;
  localparam logic [12:0] C_PCSEL = 13'h0800;
  localparam logic [12:0] C_PCW   = 13'h0400;
  localparam logic [12:0] C_PCRST = 13'h0200;
  localparam logic [12:0] C_RFWE  = 13'h0100;
  localparam logic [12:0] C_WBSEL = 13'h0080;
  localparam logic [12:0] C_MMSEL = 13'h0040;
  localparam logic [12:0] C_DMWE  = 13'h0020;
  localparam logic [12:0] C_RD1   = 13'h0008;
  localparam logic [12:0] C_RD2   = 13'h0010;
  localparam logic [12:0] C_SWEN  = 13'h0004;
  localparam logic [12:0] C_SWDAT = 13'h0002;
  localparam logic [12:0] C_SWREG = 13'h0001;

`ifdef SISC_SWAP_EN
  localparam logic        EXP_SWMUX_IDLE = 1'b0;
  localparam logic [12:0] SWP_EX  = C_SWEN;
  localparam logic [12:0] SWP_MEM = C_RFWE | C_RD2 | C_SWDAT;
  localparam logic [12:0] SWP_WB  = C_RFWE | C_RD2 | C_SWREG;
`else
  localparam logic        EXP_SWMUX_IDLE = 1'b1;
  localparam logic [12:0] SWP_EX  = C_NONE;
  localparam logic [12:0] SWP_MEM = C_NONE;
  localparam logic [12:0] SWP_WB  = C_NONE;
`endif

  function automatic logic [12:0] ctl();
    return {bus.cc_en, bus.pc_sel, bus.pc_write, bus.pc_rst, bus.rf_we, bus.wb_sel,
            bus.mm_sel, bus.dm_we, bus.rd_sel, bus.swap_en, bus.swap_data_sel,
            bus.swap_reg_sel};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of a FETCH cycle; leaves at the negedge of the next FETCH
  task automatic run_instr(input string tag, input logic [31:0] i, input logic [3:0] st,
                           input logic [31:0] a, input logic [31:0] b, input logic [15:0] pci,
                           input logic [12:0] e_dec, input logic [12:0] e_ex,
                           input logic [12:0] e_mem, input logic [12:0] e_wb,
                           input logic [31:0] e_alu, input logic [3:0] e_cc,
                           input logic [15:0] e_br);
    bus.ir = i; bus.stat = st; bus.rsa = a; bus.rsb = b; bus.pc_inc = pci;
    #1;
    check_eq({tag, ".fetch"}, 32'(ctl()), 32'(C_PCW));
    @(negedge clk); #1;
    check_eq({tag, ".decode"}, 32'(ctl()), 32'(e_dec));
    check_eq({tag, ".br_addr"}, 32'(bus.br_addr), 32'(e_br));
    @(negedge clk); #1;
    check_eq({tag, ".execute"}, 32'(ctl()), 32'(e_ex));
    check_eq({tag, ".alu"}, bus.alu_result, e_alu);
    check_eq({tag, ".cc"}, 32'(bus.cc), 32'(e_cc));
    @(negedge clk); #1;
    check_eq({tag, ".mem"}, 32'(ctl()), 32'(e_mem));
    @(negedge clk); #1;
    check_eq({tag, ".wb"}, 32'(ctl()), 32'(e_wb));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_f = 1'b1;
    bus.ir = 32'h0; bus.stat = 4'h0; bus.rsa = 32'h0; bus.rsb = 32'h0; bus.pc_inc = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_eq("reset.ctl", 32'(ctl()), 32'(C_PCRST));
    check_eq("reset.swap_mux", 32'(bus.swap_mux), 32'(EXP_SWMUX_IDLE));
    rst_f = 1'b0;
    @(negedge clk);

    //         tag     ir            stat  rsa           rsb           pc_inc
    run_instr("add",  32'h1112_3000, 4'h0, 32'h7FFF_FFFF, 32'h1,        16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h8000_0000, 4'b0110, 16'h0);
    run_instr("sub",  32'h1212_3000, 4'h0, 32'h5,         32'h5,        16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h0, 4'b1001, 16'h0);
    run_instr("addi", 32'h2110_FFFF, 4'h0, 32'hA,         32'h0,        16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h9, 4'b1000, 16'h0);
    run_instr("shl",  32'h1812_3000, 4'h0, 32'h8000_0001, 32'h1,        16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h2, 4'b1000, 16'h0);
    run_instr("shl0", 32'h1812_3000, 4'h0, 32'h8000_0001, 32'h0,        16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h8000_0001, 4'b0010, 16'h0);
    run_instr("shr",  32'h1912_3000, 4'h0, 32'h3,         32'h1,        16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h1, 4'b1000, 16'h0);
    run_instr("xor",  32'h1612_3000, 4'h0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h0, 4'b0001, 16'h0);
    run_instr("or",   32'h1412_3000, 4'h0, 32'h0F00_0000, 32'h0000_00F0, 16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h0F00_00F0, 4'b0000, 16'h0);
    run_instr("and",  32'h1512_3000, 4'h0, 32'hFF00_FF00, 32'h0FF0_0FF0, 16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h0F00_0F00, 4'b0000, 16'h0);
    run_instr("not",  32'h1312_3000, 4'h0, 32'h0,         32'h0,        16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'hFFFF_FFFF, 4'b0010, 16'h0);
    run_instr("fn7",  32'h1712_3000, 4'h0, 32'h5,         32'h5,        16'h0,
              C_NONE, C_CCEN, C_NONE, C_RFWE, 32'h0, 4'b0001, 16'h0);
    run_instr("brr_t", 32'h5100_FFFE, 4'h1, 32'h0,        32'h0,        16'h0010,
              C_PCSEL | C_PCW, C_NONE, C_NONE, C_NONE, 32'h0, 4'b0001, 16'h000E);
    run_instr("brr_n", 32'h5100_FFFE, 4'h0, 32'h0,        32'h0,        16'h0010,
              C_NONE, C_NONE, C_NONE, C_NONE, 32'h0, 4'b0001, 16'h000E);
    run_instr("bra_m0", 32'h4000_1234, 4'hF, 32'h0,       32'h0,        16'h0,
              C_NONE, C_NONE, C_NONE, C_NONE, 32'h0, 4'b0001, 16'h1234);
    run_instr("bne_m0", 32'h6000_1234, 4'hF, 32'h0,       32'h0,        16'h0,
              C_PCSEL | C_PCW, C_NONE, C_NONE, C_NONE, 32'h0, 4'b0001, 16'h1234);
    run_instr("bnr_t", 32'h7200_0005, 4'h0, 32'h0,        32'h0,        16'h0100,
              C_PCSEL | C_PCW, C_NONE, C_NONE, C_NONE, 32'h0, 4'b1001, 16'h0105);
    run_instr("lod",  32'h8112_0004, 4'h0, 32'h100,       32'h0,        16'h0,
              C_NONE, C_NONE, C_MMSEL, C_RFWE | C_WBSEL | C_RD1 | C_MMSEL,
              32'h104, 4'b0000, 16'h0);
    run_instr("str",  32'h9012_FFFC, 4'h0, 32'h100,       32'h0,        16'h0,
              C_NONE, C_NONE, C_DMWE, C_NONE, 32'hFC, 4'b1000, 16'h0);
    run_instr("swp",  32'hA012_0000, 4'h0, 32'h3,         32'h9,        16'h0,
              C_NONE, SWP_EX, SWP_MEM, SWP_WB, 32'h0, 4'b0001, 16'h0);
    run_instr("nop3", 32'h3000_0000, 4'hF, 32'h0,         32'h0,        16'h0,
              C_NONE, C_NONE, C_NONE, C_NONE, 32'h0, 4'b0001, 16'h0);

    // Halt is sticky and silent
    bus.ir = 32'hF000_0000; bus.stat = 4'hF; bus.rsa = 32'h0; bus.rsb = 32'h0;
    #1;
    check_eq("hlt.fetch", 32'(ctl()), 32'(C_PCW));
    @(negedge clk); #1;
    check_eq("hlt.decode", 32'(ctl()), 32'(C_NONE));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      check_eq($sformatf("hlt.halt%0d", k), 32'(ctl()), 32'(C_NONE));
    end
    check_eq("hlt.swap_mux", 32'(bus.swap_mux), 32'(EXP_SWMUX_IDLE));

    // Reset leaves HALT
    rst_f = 1'b1;
    @(negedge clk); #1;
    check_eq("halt_rst.ctl", 32'(ctl()), 32'(C_PCRST));
    rst_f = 1'b0;
    @(negedge clk); #1;
    check_eq("halt_rst.fetch", 32'(ctl()), 32'(C_PCW));

    // Reset during EXECUTE aborts the instruction before any write
    bus.ir = 32'h1112_3000; bus.rsa = 32'h1; bus.rsb = 32'h1;
    @(negedge clk); #1;
    @(negedge clk); #1;
    check_eq("abort.execute", 32'(ctl()), 32'(C_CCEN));
    rst_f = 1'b1;
    @(negedge clk); #1;
    check_eq("abort.start", 32'(ctl()), 32'(C_PCRST));
    rst_f = 1'b0;
    @(negedge clk); #1;
    check_eq("abort.fetch", 32'(ctl()), 32'(C_PCW));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
